ascon_ti_unmask: RTL and testbench

Word-serial share recombiner for the 4-share threshold-implementation Ascon datapath. It accepts a complete 320-bit Ascon state as four Boolean shares, recombines one 64-bit lane per step through a registered two-level XOR tree with fresh-mask refresh, and streams the unmasked lanes x0..x4 to the tag/ciphertext output logic. This block is the decoding end of the masked state that the TI substitution layer produces. It zeroizes all share-holding registers when a transfer completes.

---
 rtl/ascon_ti_unmask.sv | 125 ++++++++++++
 tb/tb_ascon_ti_unmask.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ti_unmask.sv
// Share recombiner for the 4-share TI Ascon state: one 64-bit lane per two cycles,
// mask-refreshed two-level XOR tree, zeroizing every share register on completion or flush.
module ascon_ti_unmask (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_share0,
  input  logic [319:0] in_share1,
  input  logic [319:0] in_share2,
  input  logic [319:0] in_share3,
  input  logic [63:0]  rnd,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic [2:0]   out_idx,
  output logic         out_last
);

  typedef enum logic [1:0] {IDLE, ST_A, ST_B} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [319:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [63:0]   a_q, a_d, b_q, b_d;

  // Lane 0 (x0) sits in the most significant 64 bits.
  function automatic logic [63:0] lane_sel(input logic [319:0] sh, input logic [2:0] idx);
    case (idx)
      3'd0:    return sh[319:256];
      3'd1:    return sh[255:192];
      3'd2:    return sh[191:128];
      3'd3:    return sh[127:64];
      default: return sh[63:0];
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    sh3_d   = sh3_q;
    a_d     = a_q;
    b_d     = b_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      sh0_d   = '0;
      sh1_d   = '0;
      sh2_d   = '0;
      sh3_d   = '0;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh0_d   = in_share0;
            sh1_d   = in_share1;
            sh2_d   = in_share2;
            sh3_d   = in_share3;
            idx_d   = '0;
            state_d = ST_A;
          end
        end
        ST_A: begin
          // Pairs {0,1} and {2,3} stay in separate cones until after a_q/b_q.
          a_d     = lane_sel(sh0_q, idx_q) ^ lane_sel(sh1_q, idx_q) ^ rnd;
          b_d     = lane_sel(sh2_q, idx_q) ^ lane_sel(sh3_q, idx_q) ^ rnd;
          state_d = ST_B;
        end
        ST_B: begin
          if (out_ready) begin
            if (idx_q == 3'd4) begin
              sh0_d   = '0;
              sh1_d   = '0;
              sh2_d   = '0;
              sh3_d   = '0;
              a_d     = '0;
              b_d     = '0;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_A;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sh3_q   <= sh3_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == ST_B);
  assign out_data  = out_valid ? (a_q ^ b_q) : 64'd0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 3'd4);

endmodule

// File: tb/tb_ascon_ti_unmask.sv
// Randomized bench for ascon_ti_unmask: the expected lanes come straight from the
// plain (unmasked) Ascon state, and handshake edges from the fixed 2-cycle lane cadence.
module tb_ascon_ti_unmask;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] in_share0, in_share1, in_share2, in_share3;
  logic [63:0]  rnd;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [2:0]   out_idx;
  logic         out_last;

  int checks;
  int errors;

  ascon_ti_unmask dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_share0 (in_share0),
    .in_share1 (in_share1),
    .in_share2 (in_share2),
    .in_share3 (in_share3),
    .rnd       (rnd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Splits a plain state into four random Boolean shares on the input ports.
  task automatic gen_shares(input logic [319:0] s);
    in_share1 = rand320();
    in_share2 = rand320();
    in_share3 = rand320();
    in_share0 = s ^ in_share1 ^ in_share2 ^ in_share3;
  endtask

  // rmode: 0 = rnd zero, 1 = A5/5A toggle, 2 = random. stall_lane < 0 disables the stall.
  task automatic run_xfer(input logic [319:0] s, input int rmode, input int stall_lane,
                          input int stall_n, input bit hold_iv, output logic [319:0] got);
    int n, lane, sc, exp_edge;
    logic [63:0] held, d;
    bit hs;
    got = '0; n = 0; lane = 0; sc = 0; held = '0;
    @(negedge clk);
    chk("in_ready_before_accept", 320'(in_ready), 320'(1));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold_iv) in_share0 = ~in_share0;
    else in_valid = 1'b0;
    while (lane < 5 && n < 60) begin
      @(negedge clk);
      case (rmode)
        0:       rnd = 64'd0;
        1:       rnd = (n % 2 == 1) ? 64'h5A5A5A5A5A5A5A5A : 64'hA5A5A5A5A5A5A5A5;
        default: rnd = {$urandom, $urandom};
      endcase
      out_ready = 1'b1;
      d = out_data;
      if (out_valid) begin
        if (lane == stall_lane && sc > 0) begin
          chk("stall_data", 320'(out_data), 320'(held));
          chk("stall_idx", 320'(out_idx), 320'(lane));
        end else begin
          chk("lane_data", 320'(out_data), 320'(s[(4-lane)*64 +: 64]));
          chk("lane_idx", 320'(out_idx), 320'(lane));
          chk("lane_last", 320'(out_last), 320'(lane == 4));
        end
        if (lane == stall_lane && sc < stall_n) begin
          if (sc == 0) held = out_data;
          out_ready = 1'b0;
          sc++;
        end
        if (lane == 4) in_valid = 1'b0;
      end
      hs = out_valid && out_ready;
      @(posedge clk);
      n++;
      if (hs) begin
        got[(4-lane)*64 +: 64] = d;
        exp_edge = 2 * (lane + 1) + ((stall_lane >= 0 && lane >= stall_lane) ? stall_n : 0);
        chk("handshake_edge", 320'(n), 320'(exp_edge));
        lane++;
      end
    end
    chk("xfer_done", 320'(lane), 320'(5));
  endtask

  // Called right after the last-lane handshake edge.
  task automatic post_checks();
    #1;
    chk("post_in_ready", 320'(in_ready), 320'(1));
    chk("post_out_valid", 320'(out_valid), 320'(0));
    chk("post_out_data", 320'(out_data), 320'(0));
    chk("post_sh0", dut.sh0_q, 320'(0));
    chk("post_sh1", dut.sh1_q, 320'(0));
    chk("post_sh2", dut.sh2_q, 320'(0));
    chk("post_sh3", dut.sh3_q, 320'(0));
    chk("post_a", 320'(dut.a_q), 320'(0));
    chk("post_b", 320'(dut.b_q), 320'(0));
  endtask

  initial begin
    logic [319:0] s, got, got1, got2;
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; rnd = '0;
    in_share0 = '0; in_share1 = '0; in_share2 = '0; in_share3 = '0;
    #12;
    chk("rst_in_ready", 320'(in_ready), 320'(1));
    chk("rst_out_valid", 320'(out_valid), 320'(0));
    chk("rst_out_data", 320'(out_data), 320'(0));
    chk("rst_out_idx", 320'(out_idx), 320'(0));
    chk("rst_out_last", 320'(out_last), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic recombine with in_valid held high while busy.
    s = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'hFFFFFFFFFFFFFFFF,
         64'h8000000000000001};
    gen_shares(s);
    run_xfer(s, 2, -1, 0, 1'b1, got);
    chk("basic_all", got, s);
    post_checks();

    // Same shares, different randomness.
    s = rand320();
    gen_shares(s);
    run_xfer(s, 0, -1, 0, 1'b0, got1);
    run_xfer(s, 1, -1, 0, 1'b0, got2);
    chk("rnd_indep", got2, got1);
    chk("rnd_value", got1, s);

    // Backpressure on lane 2.
    s = rand320();
    gen_shares(s);
    run_xfer(s, 2, 2, 3, 1'b0, got);
    chk("stall_all", got, s);
    post_checks();

    // Flush during lane 1 presentation.
    s = rand320();
    gen_shares(s);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 3'd1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_lane1", 320'(out_valid && out_idx == 3'd1), 320'(1));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_out_valid", 320'(out_valid), 320'(0));
    chk("flush_in_ready", 320'(in_ready), 320'(1));
    chk("flush_idx", 320'(out_idx), 320'(0));
    chk("flush_sh0", dut.sh0_q, 320'(0));
    chk("flush_sh3", dut.sh3_q, 320'(0));
    chk("flush_a", 320'(dut.a_q), 320'(0));
    chk("flush_b", 320'(dut.b_q), 320'(0));
    s = rand320();
    gen_shares(s);
    run_xfer(s, 2, -1, 0, 1'b0, got);
    chk("after_flush_all", got, s);
    post_checks();

    // Asynchronous reset in the middle of lane 3.
    s = rand320();
    gen_shares(s);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 3'd3) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_lane3", 320'(out_valid && out_idx == 3'd3), 320'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 320'(out_valid), 320'(0));
    chk("arst_in_ready", 320'(in_ready), 320'(1));
    chk("arst_out_data", 320'(out_data), 320'(0));
    chk("arst_out_last", 320'(out_last), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_release_idle", 320'(in_ready), 320'(1));

    // Random bundles with random stalls.
    for (int k = 0; k < 4; k++) begin
      s = rand320();
      gen_shares(s);
      run_xfer(s, 2, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0, got);
      chk("rand_all", got, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
